// File: rtl/prng_pkg.sv
// prng_pkg: LFSR step function and checker state encoding shared by the
// PRBS generator and checker so both agree on the sequence by construction.
package prng_pkg;

    localparam logic [7:0] LFSR_POLY = 8'h1D;

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    function automatic logic [7:0] lfsr_next(input logic [7:0] q);
        return {q[6:0], 1'b0} ^ (q[7] ? LFSR_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/prbs_checker.sv
// prbs_checker: self-seeding receive checker for the 8-bit LFSR sequence;
// locks after LOCK_CNT good predictions, then flywheels and counts errors.
module prbs_checker
    import prng_pkg::*;
#(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int CNT_W    = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [7:0]       Data_In,
    input  logic             Data_Valid,
    input  logic             Clr_Err,
    output logic             Locked,
    output logic             Err_Pulse,
    output logic [CNT_W-1:0] Err_Cnt,
    output logic [7:0]       Expected
);

    chk_state_t       state_q, state_d;
    logic [7:0]       exp_q, exp_d;
    logic [3:0]       match_q, match_d;
    logic [3:0]       loss_q, loss_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= SEED;
            exp_q   <= 8'h00;
            match_q <= '0;
            loss_q  <= '0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            match_q <= match_d;
            loss_q  <= loss_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        match_d = match_q;
        loss_d  = loss_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        if (Data_Valid) begin
            if (state_q == LOCKED) begin
                // Once locked the prediction flywheels; the input never reloads it.
                exp_d = lfsr_next(exp_q);
                if (Data_In == exp_q) begin
                    loss_d = '0;
                end else begin
                    pulse_d = 1'b1;
                    cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                    loss_d  = loss_q + 4'd1;
                    if (loss_d == 4'(LOSS_CNT)) begin
                        state_d = SEED;
                        loss_d  = '0;
                        match_d = '0;
                    end
                end
            end else if (state_q == TRACK && Data_In == exp_q) begin
                match_d = match_q + 4'd1;
                exp_d   = lfsr_next(Data_In);
                if (match_d == 4'(LOCK_CNT)) begin
                    state_d = LOCKED;
                    loss_d  = '0;
                end
            end else if (Data_In != 8'h00) begin
                exp_d   = lfsr_next(Data_In);
                match_d = '0;
                state_d = TRACK;
            end else begin
                state_d = SEED;
            end
        end
        if (Clr_Err) cnt_d = '0;
    end

    assign Locked    = (state_q == LOCKED);
    assign Err_Pulse = pulse_q;
    assign Err_Cnt   = cnt_q;
    assign Expected  = exp_q;

endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: directed plus randomized stimulus against a behavioural
// model of the PRBS checker's lock / flywheel / error-count rules.
module tb_prbs_checker;

    localparam int LOCK_CNT = 4;
    localparam int LOSS_CNT = 3;
    localparam int CNT_W    = 4;
    localparam int CMAX     = (1 << CNT_W) - 1;

    logic             Clk = 1'b0;
    logic             Rst = 1'b0;
    logic [7:0]       Data_In = 8'h00;
    logic             Data_Valid = 1'b0;
    logic             Clr_Err = 1'b0;
    logic             Locked;
    logic             Err_Pulse;
    logic [CNT_W-1:0] Err_Cnt;
    logic [7:0]       Expected;

    prbs_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Rst(Rst), .Data_In(Data_In), .Data_Valid(Data_Valid),
        .Clr_Err(Clr_Err), .Locked(Locked), .Err_Pulse(Err_Pulse),
        .Err_Cnt(Err_Cnt), .Expected(Expected)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: mode 0 hunting for a seed, 1 verifying, 2 locked.
    int         m_mode = 0;
    logic [7:0] m_exp = 8'h00;
    int         m_run = 0;
    int         m_miss = 0;
    int         m_cnt = 0;
    bit         m_pulse = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] step(input logic [7:0] q);
        int v;
        v = int'(q) * 2;
        if (v > 255) v = (v - 256) ^ 29;
        return v[7:0];
    endfunction

    task automatic model_reset();
        m_mode = 0; m_exp = 8'h00; m_run = 0; m_miss = 0; m_cnt = 0; m_pulse = 0;
    endtask

    task automatic model(input bit v, input logic [7:0] d, input bit clr);
        m_pulse = 0;
        if (v) begin
            if (m_mode == 2) begin
                if (d != m_exp) begin
                    m_pulse = 1;
                    if (m_cnt < CMAX) m_cnt++;
                    m_miss++;
                    if (m_miss == LOSS_CNT) begin m_mode = 0; m_miss = 0; m_run = 0; end
                end else m_miss = 0;
                m_exp = step(m_exp);
            end else if (m_mode == 1 && d == m_exp) begin
                m_run++;
                m_exp = step(d);
                if (m_run == LOCK_CNT) begin m_mode = 2; m_miss = 0; end
            end else if (d != 8'h00) begin
                m_exp = step(d); m_run = 0; m_mode = 1;
            end else m_mode = 0;
        end
        if (clr) m_cnt = 0;
    endtask

    task automatic cyc(input bit v, input logic [7:0] d, input bit clr);
        Data_Valid = v; Data_In = d; Clr_Err = clr;
        @(posedge Clk);
        model(v, d, clr);
        #1;
        check("locked", 32'(Locked), 32'(m_mode == 2));
        check("err_pulse", 32'(Err_Pulse), 32'(m_pulse));
        check("err_cnt", 32'(Err_Cnt), 32'(m_cnt));
        check("expected", 32'(Expected), 32'(m_exp));
        Data_Valid = 1'b0; Clr_Err = 1'b0;
    endtask

    task automatic feed(input logic [7:0] d);
        cyc(1'b1, d, 1'b0);
    endtask

    task automatic relock();
        feed(8'h01); feed(8'h02); feed(8'h04); feed(8'h08); feed(8'h10);
    endtask

    task automatic do_reset();
        #2 Rst = 1'b0;
        model_reset();
        #1;
        check("rst_locked", 32'(Locked), 32'd0);
        check("rst_cnt", 32'(Err_Cnt), 32'd0);
        check("rst_expected", 32'(Expected), 32'd0);
        check("rst_pulse", 32'(Err_Pulse), 32'd0);
        @(posedge Clk);
        #1 Rst = 1'b1;
    endtask

    initial begin
        #12;
        check("por_locked", 32'(Locked), 32'd0);
        check("por_expected", 32'(Expected), 32'd0);
        check("por_cnt", 32'(Err_Cnt), 32'd0);
        @(posedge Clk);
        #1 Rst = 1'b1;

        relock();
        check("lock_locked", 32'(Locked), 32'd1);
        check("lock_expected", 32'(Expected), 32'h20);

        feed(8'h20); feed(8'h40); feed(8'hFF);
        check("flywheel_pulse", 32'(Err_Pulse), 32'd1);
        feed(8'h1D);
        check("flywheel_nopulse", 32'(Err_Pulse), 32'd0);
        feed(8'h3A);
        check("flywheel_cnt", 32'(Err_Cnt), 32'd1);
        check("flywheel_locked", 32'(Locked), 32'd1);

        repeat (3) feed(8'h55);
        check("loss_locked", 32'(Locked), 32'd0);
        relock();
        check("relock", 32'(Locked), 32'd1);

        repeat (3) feed(8'h55);
        repeat (5) feed(8'h00);
        check("zero_seed", 32'(Locked), 32'd0);
        feed(8'h01);
        for (int i = 0; i < 10; i++) cyc(1'b0, 8'($urandom), 1'b0);
        feed(8'h02); feed(8'h04); feed(8'h08); feed(8'h10);
        check("gap_lock", 32'(Locked), 32'd1);

        do_reset();
        relock();
        for (int i = 0; i < 20; i++) begin
            feed(~m_exp);
            feed(m_exp);
        end
        check("sat_cnt", 32'(Err_Cnt), 32'(CMAX));
        cyc(1'b1, ~m_exp, 1'b1);
        check("clr_cnt", 32'(Err_Cnt), 32'd0);
        check("clr_pulse", 32'(Err_Pulse), 32'd1);

        for (int i = 0; i < 3000; i++) begin
            int r;
            logic [7:0] d;
            r = int'($urandom_range(0, 9));
            d = (m_mode != 0 && r < 7) ? m_exp : (r == 7 ? 8'h00 : 8'($urandom));
            cyc($urandom_range(0, 3) != 0, d, $urandom_range(0, 40) == 0);
            if (i % 700 == 699) do_reset();
        end

        do_reset();
        relock();
        feed(~m_exp); feed(m_exp); feed(~m_exp);
        check("midlock_cnt", 32'(Err_Cnt), 32'd2);
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
